// File: rtl/mem_responder_pkg.sv
// Shared encodings for the unified memory responder.
// Size codes, FSM states and the alignment check.
package mem_responder_pkg;

  localparam logic [1:0] MEM_SIZE_B    = 2'b00;
  localparam logic [1:0] MEM_SIZE_H    = 2'b01;
  localparam logic [1:0] MEM_SIZE_W    = 2'b10;
  localparam logic [1:0] MEM_SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'b00,
    MEM_ST_WAIT = 2'b01,
    MEM_ST_RESP = 2'b10
  } mem_state_e;

  function automatic logic mem_bad_align(
    input logic [1:0] size,
    input logic [1:0] lane
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      (size == MEM_SIZE_H):    bad = lane[0];
      (size == MEM_SIZE_W):    bad = |lane;
      (size == MEM_SIZE_RSVD): bad = 1'b1;
      default:                 bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_responder_lane_align.sv
// Little-endian lane extract/extend for loads and
// read-modify-write merge for byte/half stores.
module mem_lane_align
  import mem_responder_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_sext,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wmerge
);

  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [31:0] w_bshift;
  logic [31:0] w_hshift;
  logic [7:0]  w_b;
  logic [15:0] w_h;

  assign w_bsh    = {i_lane, 3'b000};
  assign w_hsh    = {i_lane[1], 4'b0000};
  assign w_bshift = i_old >> w_bsh;
  assign w_hshift = i_old >> w_hsh;
  assign w_b      = w_bshift[7:0];
  assign w_h      = w_hshift[15:0];

  always_comb begin
    o_rdata = i_old;
    unique case (1'b1)
      (i_size == MEM_SIZE_B):
        o_rdata = {{24{i_sext & w_b[7]}}, w_b};
      (i_size == MEM_SIZE_H):
        o_rdata = {{16{i_sext & w_h[15]}}, w_h};
      default:
        o_rdata = i_old;
    endcase
  end

  always_comb begin
    o_wmerge = i_wdata;
    unique case (1'b1)
      (i_size == MEM_SIZE_B):
        o_wmerge = (i_old & ~(32'h0000_00FF << w_bsh))
                 | ({24'h0, i_wdata[7:0]} << w_bsh);
      (i_size == MEM_SIZE_H):
        o_wmerge = (i_old & ~(32'h0000_FFFF << w_hsh))
                 | ({16'h0, i_wdata[15:0]} << w_hsh);
      default:
        o_wmerge = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Unified I/D memory responder with wait states and lane handling.
// Define MEM_BOUNDS_CHECK_EN to flag out-of-range addresses as errors.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2 + 2;
  localparam int CW    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] WAIT_INIT =
    CW'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  mem_state_e      r_state;
  mem_state_e      w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_accept;

  logic [AW-1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [1:0]      r_size;
  logic            r_sext;
  logic            r_wr;
  logic            r_err;

  logic [31:0]     r_mem [DEPTH];

  logic            w_oob;
  logic            w_err_in;
  logic            w_we;
  logic [31:0]     w_old;
  logic [31:0]     w_rd_ext;
  logic [31:0]     w_wmerge;

`ifdef MEM_BOUNDS_CHECK_EN
  assign w_oob = |addr[31:AW];
`else
  logic w_unused_hi;
  assign w_unused_hi = ^addr[31:AW];
  assign w_oob       = 1'b0;
`endif

  assign w_err_in = mem_bad_align(size, addr[1:0])
                  | (mem_read & mem_write)
                  | w_oob;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    unique case (r_state)
      MEM_ST_IDLE: begin
        if (mem_read | mem_write) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = MEM_ST_RESP;
          end else begin
            w_state_nxt = MEM_ST_WAIT;
            w_cnt_nxt   = WAIT_INIT;
          end
        end
      end
      MEM_ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = MEM_ST_RESP;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      MEM_ST_RESP: w_state_nxt = MEM_ST_IDLE;
      default:     w_state_nxt = MEM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MEM_ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= MEM_SIZE_B;
      r_sext  <= 1'b0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr  <= addr[AW-1:0];
        r_wdata <= wdata;
        r_size  <= size;
        r_sext  <= sign_ext;
        r_wr    <= mem_write;
        r_err   <= w_err_in;
      end
    end
  end

  assign w_old = r_mem[r_addr[AW-1:2]];

  mem_lane_align u_align (
    .i_old    (w_old),
    .i_wdata  (r_wdata),
    .i_size   (r_size),
    .i_lane   (r_addr[1:0]),
    .i_sext   (r_sext),
    .o_rdata  (w_rd_ext),
    .o_wmerge (w_wmerge)
  );

  // rst_n gating keeps an aborted store from ever landing
  assign w_we = rst_n & (r_state == MEM_ST_RESP) & r_wr & ~r_err;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_addr[AW-1:2]] <= w_wmerge;
  end

  assign ready = (r_state == MEM_ST_RESP);
  assign err   = ready & r_err;
  assign busy  = (r_state != MEM_ST_IDLE);
  assign rdata = (ready & ~r_err & ~r_wr) ? w_rd_ext : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed vector bench for mem_responder.
// Table of accesses plus reset-abort and aliasing sequences.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int WC = 2;
  localparam int DL = 10;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  mem_responder #(
    .DEPTH_LOG2  (DL),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .size      (size),
    .sign_ext  (sign_ext),
    .rdata     (rdata),
    .ready     (ready),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr,
                              input logic [31:0] a,
                              input logic [31:0] d,
                              input logic [1:0] sz,
                              input logic sx,
                              input logic [31:0] er,
                              input logic ee);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.d = d;
    v.sz = sz; v.sx = sx; v.exp_rd = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic access(input int idx, input vec_t v);
    int n;
    @(negedge clk);
    mem_read  = v.rd;
    mem_write = v.wr;
    addr      = v.a;
    wdata     = v.d;
    size      = v.sz;
    sign_ext  = v.sx;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) chk("busy_on", idx, 32'(busy), 32'd1);
    end while (!ready && n < 20);
    chk("latency", idx, n, WC + 1);
    chk("err", idx, 32'(err), 32'(v.exp_err));
    if (v.rd || v.exp_err) chk("rdata", idx, rdata, v.exp_rd);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
    chk("busy_off", idx, {busy, ready}, 32'd0);
  endtask

  initial begin
    bit quiet;
    logic [31:0] alias_exp;
    logic        alias_err;

    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    addr = '0; wdata = '0; size = MEM_SIZE_W; sign_ext = 1'b0;

    vecs.push_back(mk(0,1,32'h10,32'hDEADBEEF,MEM_SIZE_W,0,0,0));
    vecs.push_back(mk(1,0,32'h10,0,MEM_SIZE_W,0,32'hDEADBEEF,0));
    vecs.push_back(mk(0,1,32'h11,32'h000000A5,MEM_SIZE_B,0,0,0));
    vecs.push_back(mk(1,0,32'h11,0,MEM_SIZE_B,1,32'hFFFFFFA5,0));
    vecs.push_back(mk(1,0,32'h11,0,MEM_SIZE_B,0,32'h000000A5,0));
    vecs.push_back(mk(1,0,32'h10,0,MEM_SIZE_W,0,32'hDEADA5EF,0));
    vecs.push_back(mk(0,1,32'h20,32'h55667788,MEM_SIZE_W,0,0,0));
    vecs.push_back(mk(0,1,32'h22,32'h00008001,MEM_SIZE_H,0,0,0));
    vecs.push_back(mk(1,0,32'h22,0,MEM_SIZE_H,1,32'hFFFF8001,0));
    vecs.push_back(mk(1,0,32'h22,0,MEM_SIZE_H,0,32'h00008001,0));
    vecs.push_back(mk(1,0,32'h21,0,MEM_SIZE_H,1,32'h0,1));
    vecs.push_back(mk(1,0,32'h20,0,MEM_SIZE_W,0,32'h80017788,0));
    vecs.push_back(mk(1,0,32'h12,0,MEM_SIZE_W,0,32'h0,1));
    vecs.push_back(mk(1,1,32'h10,32'h0,MEM_SIZE_W,0,32'h0,1));
    vecs.push_back(mk(0,1,32'h10,32'h0,MEM_SIZE_RSVD,0,32'h0,1));
    vecs.push_back(mk(1,0,32'h10,0,MEM_SIZE_W,0,32'hDEADA5EF,0));
    vecs.push_back(mk(0,1,32'h13,32'hFFFFFF7F,MEM_SIZE_B,0,0,0));
    vecs.push_back(mk(1,0,32'h10,0,MEM_SIZE_W,0,32'h7FADA5EF,0));
    vecs.push_back(mk(1,0,32'h12,0,MEM_SIZE_H,1,32'h00007FAD,0));
    vecs.push_back(mk(1,0,32'h10,0,MEM_SIZE_B,1,32'hFFFFFFEF,0));
    vecs.push_back(mk(0,1,32'h00,32'h11223344,MEM_SIZE_W,0,0,0));
    vecs.push_back(mk(0,1,32'h30,32'hCAFEF00D,MEM_SIZE_W,0,0,0));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 0, {rdata[29:0], ready, err}, 32'd0);
    chk("rst_busy", 0, 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) access(i, vecs[i]);

    // Reset during WAIT of a store must drop the store
    @(negedge clk);
    mem_write = 1'b1; mem_read = 1'b0;
    addr = 32'h30; wdata = 32'h12345678;
    size = MEM_SIZE_W; sign_ext = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 0, 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_rst", 0, {busy, ready, err}, 32'd0);
    mem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (ready) quiet = 1'b0;
    end
    chk("abort_noready", 0, 32'(quiet), 32'd1);
    access(100, mk(1,0,32'h30,0,MEM_SIZE_W,0,32'hCAFEF00D,0));

`ifdef MEM_BOUNDS_CHECK_EN
    alias_exp = 32'h0;
    alias_err = 1'b1;
`else
    alias_exp = 32'h11223344;
    alias_err = 1'b0;
`endif
    access(101, mk(1,0,32'h1000,0,MEM_SIZE_W,0,alias_exp,alias_err));
    access(102, mk(1,0,32'h0,0,MEM_SIZE_W,0,32'h11223344,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
